// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM states, data-length
// encodings, per-frame configuration snapshot and default parameter values.
package uart_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_DIV_WIDTH  = 16;

  localparam logic [1:0] DLEN_5 = 2'd0;
  localparam logic [1:0] DLEN_6 = 2'd1;
  localparam logic [1:0] DLEN_7 = 2'd2;
  localparam logic [1:0] DLEN_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic [1:0] data_bits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } tx_frame_cfg_t;

  // Mask selecting the data bits actually sent for a given length encoding.
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    logic [7:0] m;
    case (bits)
      DLEN_5:  m = 8'h1F;
      DLEN_6:  m = 8'h3F;
      DLEN_7:  m = 8'h7F;
      DLEN_8:  m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] last_data_idx(input logic [1:0] bits);
    return 3'(bits) + 3'd4;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags and a
// combinational read port showing the head entry.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data_c,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_c = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: TX FIFO, CTS synchroniser, baud down-counter and frame FSM.
// Frame configuration and divisor are snapshotted when a frame starts.
module uart_tx_core #(
  parameter int unsigned FIFO_DEPTH = uart_pkg::DEF_FIFO_DEPTH,
  parameter int unsigned DIV_WIDTH  = uart_pkg::DEF_DIV_WIDTH
) (
  input  logic                          apb_clk_in,
  input  logic                          apb_rst_in,
  input  logic                          wr_valid_in,
  input  logic [7:0]                    wr_data_in,
  output logic                          wr_ready_out,
  input  logic                          cfg_tx_en_in,
  input  logic [1:0]                    cfg_data_bits_in,
  input  logic                          cfg_parity_en_in,
  input  logic                          cfg_parity_odd_in,
  input  logic                          cfg_stop2_in,
  input  logic                          cfg_cts_en_in,
  input  logic [DIV_WIDTH-1:0]          cfg_baud_div_in,
  input  logic                          uart_ctx_in,
  output logic                          uart_txd_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          tx_busy_out,
  output logic                          tx_empty_irq_out
);

  import uart_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  tx_frame_cfg_t        cfg_q, cfg_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_q, par_d;
  logic                 cts_meta_q, cts_meta_d, cts_sync_q, cts_sync_d;

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [7:0]           fifo_rd_data, new_data;
  logic [LVL_W-1:0]     fifo_level;
  logic                 can_start, bit_end, start_frame;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (apb_clk_in),
    .rst       (apb_rst_in),
    .push      (wr_valid_in),
    .wr_data   (wr_data_in),
    .pop       (fifo_pop),
    .rd_data_c (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign can_start = ~fifo_empty & cfg_tx_en_in & (~cfg_cts_en_in | ~cts_sync_q);
  assign bit_end   = (cnt_q == '0);
  assign new_data  = fifo_rd_data & data_mask(cfg_data_bits_in);

  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    cfg_d       = cfg_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    par_d       = par_q;
    irq_d       = 1'b0;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    cts_meta_d  = uart_ctx_in;
    cts_sync_d  = cts_meta_q;

    if (state_q != ST_IDLE && !bit_end) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        txd_d       = 1'b1;
        start_frame = can_start;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          txd_d     = shift_q[0];
          bit_idx_d = '0;
          cnt_d     = div_q;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_idx_q == last_data_idx(cfg_q.data_bits)) begin
            if (cfg_q.par_en) begin
              state_d = ST_PARITY;
              txd_d   = par_q;
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
          cnt_d      = div_q;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (cfg_q.stop2 && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = div_q;
          end else if (can_start) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            irq_d   = fifo_empty;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start: pop the head byte and snapshot configuration for the whole frame.
    if (start_frame) begin
      fifo_pop        = 1'b1;
      state_d         = ST_START;
      txd_d           = 1'b0;
      cnt_d           = cfg_baud_div_in;
      div_d           = cfg_baud_div_in;
      cfg_d.data_bits = cfg_data_bits_in;
      cfg_d.par_en    = cfg_parity_en_in;
      cfg_d.par_odd   = cfg_parity_odd_in;
      cfg_d.stop2     = cfg_stop2_in;
      shift_d         = new_data;
      par_d           = (^new_data) ^ cfg_parity_odd_in;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state_q    <= ST_IDLE;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      cnt_q      <= '0;
      div_q      <= '0;
      cfg_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      cfg_q      <= cfg_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign wr_ready_out     = ~fifo_full;
  assign uart_txd_out     = txd_q;
  assign fifo_level_out   = fifo_level;
  assign tx_busy_out      = busy_q;
  assign tx_empty_irq_out = irq_q;

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, TX FIFO entries; power of 2, at least 2.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, baud divisor width.
REQ-003 SHALL have port apb_clk_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port apb_rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid_in  input  1  write request for one TX byte.
REQ-006 SHALL have port wr_data_in  input  8  TX byte; bits above the configured length are ignored.
REQ-007 SHALL have port wr_ready_out  output  1  FIFO can accept a byte.
REQ-008 SHALL have port cfg_tx_en_in  input  1  transmitter enable.
REQ-009 SHALL have port cfg_data_bits_in  input  2  data length = 5 + value (5..8 bits).
REQ-010 SHALL have port cfg_parity_en_in  input  1  parity bit present.
REQ-011 SHALL have port cfg_parity_odd_in  input  1  1 = odd parity, 0 = even parity.
REQ-012 SHALL have port cfg_stop2_in  input  1  1 = two stop bits, 0 = one stop bit.
REQ-013 SHALL have port cfg_cts_en_in  input  1  honour the CTS input.
REQ-014 SHALL have port cfg_baud_div_in  input  DIV_WIDTH  bit period = value + 1 cycles.
REQ-015 SHALL have port uart_ctx_in  input  1  CTS, active-low, asynchronous.
REQ-016 SHALL have port uart_txd_out  output  1  serial line, registered, idle high.
REQ-017 SHALL have port fifo_level_out  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port tx_busy_out  output  1  FSM not in IDLE.
REQ-019 SHALL have port tx_empty_irq_out  output  1  one-cycle done pulse.

Function
REQ-020 SHALL accept a write on an edge where wr_valid_in and wr_ready_out are both high; wr_ready_out SHALL equal !full.
REQ-021 SHALL have FSM states IDLE, START, DATA, PARITY and STOP.
REQ-022 SHALL leave IDLE for START when all hold: FIFO non-empty, cfg_tx_en_in = 1, and (cfg_cts_en_in = 0 or synchronised CTS low); the FIFO pop SHALL occur on the same edge.
REQ-023 SHALL make fifo_level_out and FIFO non-empty visible on edge E0 for a byte written into an empty FIFO at E0; START entry and uart_txd_out low SHALL follow on edge E0+1 when enabled.
REQ-024 SHALL latch data length, parity enable, parity sense, stop count and divisor on START entry; configuration changes mid-frame SHALL NOT affect the current frame.
REQ-025 SHALL hold every bit for exactly latched div + 1 cycles, counted by a down-counter reloaded at each bit boundary; div = 0 SHALL give one cycle per bit.
REQ-026 SHALL send data bits LSB first; in DATA, a bit index SHALL count up to length - 1.
REQ-027 SHALL drive the parity bit as XOR of the sent data bits, inverted when odd parity; PARITY SHALL be skipped when parity is disabled.
REQ-028 SHALL hold STOP high for one or two bit periods.
REQ-029 SHALL go directly from the final STOP cycle to START, with no idle cycle, when the REQ-022 conditions hold on that edge; otherwise it SHALL return to IDLE.
REQ-030 SHALL make a frame last (1 + length + parity + stops) × (div + 1) cycles.
REQ-031 SHALL pass uart_ctx_in through a 2-flop synchroniser; CTS and cfg_tx_en_in SHALL be evaluated only at frame start, so deassertion mid-frame SHALL never truncate a frame.
REQ-032 SHALL pulse tx_empty_irq_out for one cycle on the edge a frame's final stop bit ends with the FIFO empty and no write pending pop.
REQ-033 SHALL ignore a write while full, with no overwrite and no level change.
REQ-034 SHALL, on a simultaneous push and pop, leave the level unchanged and handle pointer wrap-around at FIFO_DEPTH.
REQ-035 SHALL keep uart_txd_out high in IDLE.

Reset
REQ-036 SHALL, on apb_rst_in high at an edge, set: state IDLE, uart_txd_out = 1, FIFO pointers and level 0, wr_ready_out = 1, tx_busy_out = 0, tx_empty_irq_out = 0, counters 0, synchroniser flops = 1 (CTS not clear).
REQ-037 SHALL, on reset mid-frame, abort the frame, return uart_txd_out high on that edge, discard FIFO contents, and raise no interrupt.

Structure
REQ-038 SHALL place the FSM state enum, data-length encoding constants and the default-parameter constants in shared package uart_pkg.
REQ-039 SHALL implement the FIFO as sub-module uart_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); the FSM, baud counter and synchroniser SHALL stay in uart_tx_core.

Verification
REQ-040 SHALL cover: div=3, 8N1, CTS disabled, write 0xA5 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop 4 cycles; frame 40 cycles; one irq pulse.
REQ-041 SHALL cover: div=0, 7 bits, odd parity, 2 stop, write 0x35 -> frame 0,1,0,1,0,1,1,0,1,1,1 and 11 cycles total.
REQ-042 SHALL cover: FIFO_DEPTH=16, tx_en=0, write 17 bytes -> 16 accepted, level 16, wr_ready 0, 17th dropped; then tx_en=1 -> 16 back-to-back frames with no idle gap; a single irq after the last frame.
REQ-043 SHALL cover: cts_en=1, CTS high, 2 bytes queued -> txd stays high; CTS low -> start bit 3 cycles later; CTS high mid-frame -> frame completes, next frame held.
REQ-044 SHALL cover: reset asserted mid-DATA with 3 bytes queued -> txd high next edge, level 0, busy 0, no irq.
REQ-045 SHALL cover: change cfg_baud_div_in and cfg_data_bits_in mid-frame -> current frame unchanged, next frame uses the new values.
